// File: rtl/bit_count_pkg.sv
// Shared definitions for the popcount / unary pattern blocks: default widths,
// FSM state encoding and a clog2 helper.
package bit_count_pkg;

    localparam int DEF_INPUT_WIDTH = 10;
    localparam int DEF_COUNT_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/unary_spread_acc.sv
// Bresenham accumulator that spreads Neff ones evenly over INPUT_WIDTH steps.
// Only instantiated when UNARY_SPREAD_EN is defined.
module unary_spread_acc
    import bit_count_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   Clr,
    input  logic                   Step,
    input  logic [COUNT_WIDTH-1:0] Neff,
    output logic                   Bit
);

    localparam logic [COUNT_WIDTH:0] WVAL = (COUNT_WIDTH + 1)'(INPUT_WIDTH);

    logic [COUNT_WIDTH:0] acc_q;
    logic [COUNT_WIDTH:0] acc_d;
    logic [COUNT_WIDTH:0] base;
    logic [COUNT_WIDTH:0] sum;

    // Clr makes the step use a zero accumulator so the first bit of a new
    // pattern is produced in the same cycle the count is accepted.
    always_comb begin
        base  = Clr ? '0 : acc_q;
        sum   = base + {1'b0, Neff};
        Bit   = (sum >= WVAL);
        acc_d = acc_q;
        if (Step) begin
            acc_d = Bit ? (sum - WVAL) : sum;
        end else if (Clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/unary_pattern_gen.sv
// Loads a count N and emits a W-bit pattern with exactly min(N, W) ones, serially
// and as a registered word. UNARY_SPREAD_EN selects spread instead of packed ones.
module unary_pattern_gen
    import bit_count_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   WrEn,
    input  logic [COUNT_WIDTH-1:0] Count,
    output logic                   Busy,
    output logic                   BitValid,
    output logic                   BitOut,
    output logic                   Done,
    output logic [INPUT_WIDTH-1:0] Pattern
);

    localparam int IDXW = clog2(INPUT_WIDTH);
    localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(INPUT_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] WCOUNT   = COUNT_WIDTH'(INPUT_WIDTH);

    logic [1:0]             state_q,    state_d;
    logic [IDXW-1:0]        idx_q,      idx_d;
    logic [COUNT_WIDTH-1:0] neff_q,     neff_d;
    logic [INPUT_WIDTH-1:0] shadow_q,   shadow_d;
    logic [INPUT_WIDTH-1:0] pattern_q,  pattern_d;
    logic                   busy_q,     busy_d;
    logic                   bitValid_q, bitValid_d;
    logic                   bitOut_q,   bitOut_d;
    logic                   done_q,     done_d;

    logic                   accept;
    logic                   advance;
    logic                   step;
    logic [IDXW-1:0]        idxNext;
    logic [COUNT_WIDTH-1:0] countSat;
    logic [COUNT_WIDTH-1:0] neffStep;
    logic                   nextBit;

    // Each bit is computed one edge ahead so BitOut/BitValid come straight from flops.
    assign countSat = (Count > WCOUNT) ? WCOUNT : Count;
    assign accept   = (state_q == S_IDLE) && WrEn;
    assign advance  = (state_q == S_SEND) && (idx_q != LAST_IDX);
    assign step     = accept || advance;
    assign idxNext  = accept ? '0 : (idx_q + IDXW'(1));
    assign neffStep = accept ? countSat : neff_q;

`ifdef UNARY_SPREAD_EN
    unary_spread_acc #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_spread_acc (
        .CLK  (CLK),
        .RSTn (RSTn),
        .Clr  (accept),
        .Step (step),
        .Neff (neffStep),
        .Bit  (nextBit)
    );
`else
    assign nextBit = (COUNT_WIDTH'(idxNext) < neffStep);
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        neff_d     = neff_q;
        shadow_d   = shadow_q;
        pattern_d  = pattern_q;
        busy_d     = busy_q;
        bitValid_d = 1'b0;
        bitOut_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (WrEn) begin
                    state_d  = S_SEND;
                    neff_d   = countSat;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                end
            end
            S_SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d   = S_DONE;
                    pattern_d = shadow_q;
                    done_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (step) begin
            idx_d             = idxNext;
            bitValid_d        = 1'b1;
            bitOut_d          = nextBit;
            shadow_d[idxNext] = nextBit;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            neff_q     <= '0;
            shadow_q   <= '0;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            bitValid_q <= 1'b0;
            bitOut_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            neff_q     <= neff_d;
            shadow_q   <= shadow_d;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            bitValid_q <= bitValid_d;
            bitOut_q   <= bitOut_d;
            done_q     <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign BitValid = bitValid_q;
    assign BitOut   = bitOut_q;
    assign Done     = done_q;
    assign Pattern  = pattern_q;

endmodule

// File: tb/tb_unary_pattern_gen.sv
// Self-checking bench for unary_pattern_gen; the expected pattern model follows
// UNARY_SPREAD_EN so the same bench covers packed and spread builds.
module tb_unary_pattern_gen;

    localparam int W  = 10;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          CLK;
    logic          RSTn;
    logic          WrEn;
    logic [CW-1:0] Count;
    logic          Busy;
    logic          BitValid;
    logic          BitOut;
    logic          Done;
    logic [W-1:0]  Pattern;

    int total;
    int bad;

    unary_pattern_gen #(
        .INPUT_WIDTH (W),
        .COUNT_WIDTH (CW)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .WrEn     (WrEn),
        .Count    (Count),
        .Busy     (Busy),
        .BitValid (BitValid),
        .BitOut   (BitOut),
        .Done     (Done),
        .Pattern  (Pattern)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: packed puts ones in the low bits; spread sets bit i whenever
    // floor(i*n/W) steps up at i+1, which places exactly n evenly spaced ones.
    function automatic logic [W-1:0] expPattern(input int cnt);
        logic [W-1:0] p;
        int n;
        n = (cnt > W) ? W : cnt;
        p = '0;
        for (int i = 0; i < W; i++) begin
`ifdef UNARY_SPREAD_EN
            p[i] = (((i + 1) * n) / W) > ((i * n) / W);
`else
            p[i] = (i < n);
`endif
        end
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input int cnt);
        WrEn  = en;
        Count = CW'(cnt);
    endtask

    // One full load: accept, collect the serial stream, check Done timing and Pattern.
    task automatic runLoad(input int cnt, input string tag);
        logic [W-1:0] serial;
        int nValid;
        int nBusy;
        int doneCyc;
        int neff;
        serial  = '0;
        nValid  = 0;
        nBusy   = 0;
        doneCyc = -1;
        neff    = (cnt > W) ? W : cnt;
        @(negedge CLK);
        applyStimulus(1'b1, cnt);
        @(posedge CLK);
        #1 applyStimulus(1'b0, $urandom_range(0, MAXC));
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge CLK);
            if (Busy) nBusy++;
            if (BitValid) begin
                if (nValid < W) serial[nValid] = BitOut;
                nValid++;
            end
            if (Done) begin
                doneCyc = k;
                break;
            end
        end
        checkOutput({tag, "_doneCycle"}, doneCyc, W + 1);
        checkOutput({tag, "_validCycles"}, nValid, W);
        checkOutput({tag, "_busyCycles"}, nBusy, W + 1);
        checkOutput({tag, "_serial"}, 32'(serial), 32'(expPattern(cnt)));
        checkOutput({tag, "_pattern"}, 32'(Pattern), 32'(expPattern(cnt)));
        checkOutput({tag, "_popcount"}, $countones(Pattern), neff);
        @(negedge CLK);
        checkOutput({tag, "_idleBusy"}, 32'(Busy), 0);
        checkOutput({tag, "_idleDone"}, 32'(Done), 0);
    endtask

    int seq [3 * (W + 2)];
    int doneSeen;
    int strayEvents;
    logic [W-1:0] held;

    initial begin
        total = 0;
        bad   = 0;
        RSTn  = 1'b0;
        applyStimulus(1'b0, 0);

        // Reset and idle behaviour
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("rst_pattern", 32'(Pattern), 0);
        checkOutput("rst_busy", 32'(Busy), 0);
        checkOutput("rst_done", 32'(Done), 0);
        checkOutput("rst_bitvalid", 32'(BitValid), 0);

        // Pattern holds between loads; then reset mid-SEND discards the load
        runLoad(3, "pre_reset");
        held = Pattern;
        repeat (3) @(negedge CLK);
        checkOutput("hold_pattern", 32'(Pattern), 32'(held));
        @(negedge CLK);
        applyStimulus(1'b1, 5);
        @(posedge CLK);
        #1 applyStimulus(1'b0, 0);
        repeat (4) @(negedge CLK);
        checkOutput("midsend_busy_before", 32'(Busy), 1);
        #2 RSTn = 1'b0;
        #1;
        checkOutput("async_busy", 32'(Busy), 0);
        checkOutput("async_bitvalid", 32'(BitValid), 0);
        checkOutput("async_bitout", 32'(BitOut), 0);
        checkOutput("async_pattern", 32'(Pattern), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        strayEvents = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge CLK);
            if (Done || BitValid || Busy) strayEvents++;
        end
        checkOutput("no_done_after_reset", strayEvents, 0);

        // Directed counts including boundaries and saturation
        runLoad(3, "count3");
        runLoad(5, "count5");
        runLoad(0, "count0");
        runLoad(W, "countW");
        runLoad(MAXC, "countSat");
        runLoad(1, "count1");

        // WrEn held high with Count changing every cycle
        for (int c = 0; c < 3 * (W + 2); c++) seq[c] = $urandom_range(0, MAXC);
        doneSeen = 0;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            @(negedge CLK);
            if (Done) begin
                checkOutput("held_done_cycle", c, (W + 1) + doneSeen * (W + 2));
                if (c >= W + 1)
                    checkOutput("held_pattern", 32'(Pattern), 32'(expPattern(seq[c - (W + 1)])));
                doneSeen++;
            end
            applyStimulus(1'b1, seq[c]);
        end
        @(negedge CLK);
        applyStimulus(1'b0, 0);
        checkOutput("held_done_count", doneSeen, 3);
        repeat (W + 4) @(negedge CLK);

        // Random sweep
        for (int r = 0; r < 1000; r++) begin
            runLoad($urandom_range(0, MAXC), "sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
